// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the 32x8 single-port RAM and its burst sequencer.
package ram_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int LEN_W     = 3;
  localparam int RAM_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT
  } state_t;

endpackage

// File: rtl/ram_burst_ctrl.sv
// Burst read/write sequencer in front of the single-port RAM: auto-incrementing, wrapping address,
// 1 write beat/cycle, 1 read beat per 3 cycles, read stream held while rd_ready is low.
module ram_burst_ctrl #(
  parameter int ADDR_W = ram_pkg::ADDR_W,
  parameter int DATA_W = ram_pkg::DATA_W,
  parameter int LEN_W  = ram_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enb,
  output logic              ram_read_enb,
  input  logic [DATA_W-1:0] ram_data_out
);
  import ram_pkg::*;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    remain;
  logic [DATA_W-1:0]   rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    ram_address   = '0;
    ram_data_in   = '0;
    ram_write_enb = 1'b0;
    ram_read_enb  = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so the port reads 0 while reset is held.
        req_ready = reset;
        if (req_valid) begin
          state_d = req_write ? WR_BEAT : RD_ISSUE;
        end
      end
      WR_BEAT: begin
        wr_ready      = 1'b1;
        ram_address   = cur_addr;
        ram_data_in   = wr_data;
        ram_write_enb = wr_valid;
        if (wr_valid && remain == '0) begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        ram_read_enb = 1'b1;
        ram_address  = cur_addr;
        state_d      = RD_WAIT;
      end
      RD_WAIT: begin
        state_d = RD_OUT;
      end
      RD_OUT: begin
        rd_valid = 1'b1;
        rd_last  = (remain == '0);
        if (rd_ready) begin
          state_d = (remain == '0) ? IDLE : RD_ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr  <= '0;
      remain    <= '0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cur_addr <= req_addr;
            remain   <= req_len;
          end
        end
        WR_BEAT: begin
          if (wr_valid) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (remain != '0) begin
              remain <= remain - LEN_W'(1);
            end
          end
        end
        // RAM output register holds the word addressed in RD_ISSUE during this cycle.
        RD_WAIT: begin
          rd_data_q <= ram_data_out;
        end
        RD_OUT: begin
          if (rd_ready) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            if (remain != '0) begin
              remain <= remain - LEN_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl: behavioural 32x8 RAM plus an array reference model of its contents.
module tb_ram_burst_ctrl;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [2:0] req_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       busy;
  logic [4:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enb;
  logic       ram_read_enb;
  logic [7:0] ram_data_out;

  ram_burst_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write_enb(ram_write_enb),
    .ram_read_enb (ram_read_enb),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  logic [7:0] mem [32];
  always @(posedge clk) begin
    if (ram_write_enb) mem[ram_address] <= ram_data_in;
    if (ram_read_enb)  ram_data_out <= mem[ram_address];
  end

  logic [7:0] ref_mem [32];
  logic [7:0] wbuf [8];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic handshake(input bit wr, input logic [4:0] a, input logic [2:0] l);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("req_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [2:0] l,
                          input bit use_pat, input logic [15:0] pat);
    int i;
    int k;
    bit v;
    logic [4:0] ea;
    i = 0; k = 0;
    handshake(1'b1, a, l);
    while (i <= int'(l) && k < 64) begin
      if (use_pat && k < 16) v = pat[k];
      else v = ($urandom_range(0, 3) != 0);
      ea = a + 5'(i);
      wr_valid = v; wr_data = wbuf[i];
      @(negedge clk);
      chk("wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("wr_we", {31'd0, ram_write_enb}, {31'd0, v});
      chk("wr_no_re", {31'd0, ram_read_enb}, 32'd0);
      if (v) begin
        chk("wr_addr", {27'd0, ram_address}, {27'd0, ea});
        chk("wr_din", {24'd0, ram_data_in}, {24'd0, wbuf[i]});
      end
      @(posedge clk); #1;
      if (v) begin
        ref_mem[ea] = wbuf[i];
        i++;
      end
      k++;
    end
    wr_valid = 1'b0;
    chk("wr_beats", i, int'(l) + 1);
    @(negedge clk);
    chk("wr_idle_busy", {31'd0, busy}, 32'd0);
    chk("wr_idle_rdy", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [2:0] l, input int stall0,
                         input bit rnd, input bit abort);
    int n;
    int s;
    bit seen;
    logic [4:0] ea;
    logic [7:0] exp;
    handshake(1'b0, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      n = 0; seen = 1'b0;
      ea = a + 5'(i);
      while (!seen && n < 10) begin
        @(negedge clk);
        n++;
        if (rd_valid) begin
          seen = 1'b1;
        end else begin
          chk("rd_re_pulse", {31'd0, ram_read_enb}, {31'd0, n == 1});
          if (n == 1) chk("rd_addr", {27'd0, ram_address}, {27'd0, ea});
          chk("rd_no_we", {31'd0, ram_write_enb}, 32'd0);
          @(posedge clk); #1;
        end
      end
      chk("rd_latency", n, 3);
      if (!seen) return;
      exp = ref_mem[ea];
      chk("rd_data", {24'd0, rd_data}, {24'd0, exp});
      chk("rd_last", {31'd0, rd_last}, {31'd0, i == int'(l)});
      chk("rd_out_no_re", {31'd0, ram_read_enb}, 32'd0);
      if (abort) return;
      s = rnd ? int'($urandom_range(0, 2)) : ((i == 0) ? stall0 : 0);
      for (int j = 0; j < s; j++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_valid", {31'd0, rd_valid}, 32'd1);
        chk("stall_data", {24'd0, rd_data}, {24'd0, exp});
        chk("stall_no_re", {31'd0, ram_read_enb}, 32'd0);
      end
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
    @(negedge clk);
    chk("rd_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #3;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_en", {30'd0, ram_write_enb, ram_read_enb}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Fill every word so the reference model is fully defined.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
      do_write(5'(b * 8), 3'd7, 1'b1, 16'hFFFF);
    end

    wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
    do_write(5'd3, 3'd3, 1'b1, 16'hFFFF);
    do_read(5'd3, 3'd3, 0, 1'b0, 1'b0);

    wbuf[0] = 8'h10; wbuf[1] = 8'h11; wbuf[2] = 8'h12; wbuf[3] = 8'h13;
    do_write(5'd30, 3'd3, 1'b1, 16'hFFFF);
    do_read(5'd30, 3'd3, 0, 1'b0, 1'b0);

    do_read(5'd3, 3'd1, 5, 1'b0, 1'b0);

    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    do_write(5'd12, 3'd1, 1'b1, 16'b1001);
    do_read(5'd12, 3'd1, 0, 1'b0, 1'b0);

    // Asynchronous reset while a read beat is being presented.
    do_read(5'd4, 3'd2, 0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("arst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("arst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("arst_rd_last", {31'd0, rd_last}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ram_addr", {27'd0, ram_address}, 32'd0);
    chk("arst_ram_din", {24'd0, ram_data_in}, 32'd0);
    chk("arst_en", {30'd0, ram_write_enb, ram_read_enb}, 32'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rel_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    do_read(5'd3, 3'd3, 0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      logic [4:0] ra;
      logic [2:0] rl;
      ra = 5'($urandom_range(0, 31));
      rl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
        do_write(ra, rl, 1'b0, 16'h0);
      end else begin
        do_read(ra, rl, 0, 1'b1, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
